alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Shares one combinational ALU (aluop/porta/portb in; portout/zero/negative/overflow out) between NREQ requesters, e.g. the execute stage, the branch-compare unit and a debug port.
- Round-robin arbiter plus a 3-state sequencer.
- Each requester sees a valid/ready request channel and a valid/ready response channel.
- Sits between the requesters and the ALU instance in the datapath.

Parameters:
NREQ, 2, number of requesters (legal 2..4)
CNTW, 16, width of completed-operation counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  request valid per requester
req_ready  out  NREQ  request accepted (one-hot or zero)
req_aluop  in  NREQ*4  aluop_t per requester, requester i at bits [4i+3:4i]
req_porta  in  NREQ*32  operand A per requester, [32i+31:32i]
req_portb  in  NREQ*32  operand B per requester
resp_valid  out  NREQ  result valid, one-hot to owning requester
resp_ready  in  NREQ  requester consumes result
resp_portout  out  32  registered ALU result
resp_zero  out  1  registered zero flag
resp_negative  out  1  registered negative flag
resp_overflow  out  1  registered overflow flag
alu_aluop  out  4  to ALU
alu_porta  out  32  to ALU
alu_portb  out  32  to ALU
alu_portout  in  32  from ALU
alu_zero  in  1  from ALU
alu_negative  in  1  from ALU
alu_overflow  in  1  from ALU
busy  out  1  high whenever state != IDLE
op_count  out  CNTW  completed responses, wraps at 2^CNTW

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - state=IDLE; ptr=NREQ-1, so requester 0 has first priority.
  - Operand, owner and result registers = 0; op_count=0.
  - All resp_valid=0, req_ready=0, busy=0.
  - alu_* outputs = 0.
- State IDLE:
  - Winner = first i with req_valid[i]=1, searching ptr+1, ptr+2, ... modulo NREQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits 0.
  - If no req_valid bit is set: req_ready=0, stay in IDLE.
  - On handshake: latch that requester's aluop/porta/portb into the operand register; owner<=winner; ptr<=winner; go to EXEC.
- State EXEC:
  - alu_aluop/porta/portb are driven from the operand register (held stable in EXEC and RESP; 0 in IDLE).
  - At the clock edge, capture alu_portout/zero/negative/overflow into the result registers; go to RESP.
- State RESP:
  - resp_valid[owner]=1; resp_* outputs are driven from the result registers and held stable until the handshake.
  - On resp_ready[owner]=1: op_count<=op_count+1 (wrap), go to IDLE.
  - resp_ready bits of non-owners are ignored.
- Latency and throughput:
  - Request handshake at edge N; resp_valid high during cycle N+2 (after edges N+1 and N+2 counted from accept).
  - Minimum throughput: one operation per 3 cycles.
- Arbitration:
  - Fairness: a continuously requesting requester is granted within NREQ grants.
  - Simultaneous requests in IDLE: exactly one is granted, by the round-robin rule; the losers keep valid and are not accepted.
  - A requester that drops req_valid before its grant is simply skipped; there is no starvation bookkeeping.
- Result flags: the block does no arithmetic on results; it passes through the ALU's portout and flags exactly as captured. The resp_* registers hold their last value while in IDLE.
- Reset mid-operation (EXEC or RESP): the pending result is discarded, resp_valid drops immediately, and state and ptr return to reset values. op_count does not count the dropped operation.
- op_count wraps from 2^CNTW-1 to 0.

Test Plan:
- Single op: req_valid=01, ALU_ADD, A=5, B=7 -> req_ready=01 same cycle; resp_valid=01 two cycles later; portout=12, zero=0, negative=0, overflow=0; op_count=1.
- Overflow passthrough: ALU_ADD, A=0x7FFFFFFF, B=1 -> portout=0x80000000, negative=1, overflow=1; ALU_SUB with A=B=0x1234 -> portout=0, zero=1.
- Contention, NREQ=2, both valid continuously for 4 ops -> grant order 0,1,0,1; each response goes only to the owner; op_count=4.
- Backpressure: resp_ready held 0 for 5 cycles -> state stays RESP, resp_* stable, req_ready stays 0 despite pending requests; ready on cycle 6 -> IDLE next cycle.
- Async reset asserted in EXEC, mid-cycle -> resp_valid=0, busy=0 immediately; after release requester 0 wins a tie; op_count unchanged from 0.
- Counter wrap, CNTW=4: 17 completed ops -> op_count=1.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU among NREQ requesters
//   req_*  : per-requester valid/ready request channel (aluop, porta, portb packed by index)
//   resp_* : per-requester valid/ready response channel, shared registered result and flags
//   alu_*  : operands out to the external ALU, result and flags back from it
//   busy   : sequencer not idle; op_count: completed responses, wrapping
module alu_share_ctrl #(
  parameter int NREQ = 2,
  parameter int CNTW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*4-1:0]  req_aluop,
  input  logic [NREQ*32-1:0] req_porta,
  input  logic [NREQ*32-1:0] req_portb,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [31:0]        resp_portout,
  output logic               resp_zero,
  output logic               resp_negative,
  output logic               resp_overflow,
  output logic [3:0]         alu_aluop,
  output logic [31:0]        alu_porta,
  output logic [31:0]        alu_portb,
  input  logic [31:0]        alu_portout,
  input  logic               alu_zero,
  input  logic               alu_negative,
  input  logic               alu_overflow,
  output logic               busy,
  output logic [CNTW-1:0]    op_count
);
  localparam int IW = (NREQ > 2) ? 2 : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, win, idx;
  logic found, hs_req, hs_resp;
  logic [3:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic z_q, z_d, n_q, n_d, v_q, v_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  // search starts just after the last winner so every requester gets a turn
  always_comb begin
    found = 1'b0;
    win = ptr_q;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign hs_req = state_q == IDLE && found;
  assign hs_resp = state_q == RESP && resp_ready[owner_q];
  always_comb begin
    state_d = hs_req ? EXEC : state_q == EXEC ? RESP : hs_resp ? IDLE : state_q;
    ptr_d = hs_req ? win : ptr_q;
    owner_d = hs_req ? win : owner_q;
    op_d = hs_req ? req_aluop[4*win +: 4] : op_q;
    a_d = hs_req ? req_porta[32*win +: 32] : a_q;
    b_d = hs_req ? req_portb[32*win +: 32] : b_q;
    out_d = state_q == EXEC ? alu_portout : out_q;
    z_d = state_q == EXEC ? alu_zero : z_q;
    n_d = state_q == EXEC ? alu_negative : n_q;
    v_d = state_q == EXEC ? alu_overflow : v_q;
    cnt_d = cnt_q + CNTW'(hs_resp);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(NREQ - 1);
      owner_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      out_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      out_q <= out_d;
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = state_q != IDLE;
  assign req_ready = hs_req ? NREQ'(1) << win : '0;
  assign resp_valid = state_q == RESP ? NREQ'(1) << owner_q : '0;
  assign alu_aluop = busy ? op_q : '0;
  assign alu_porta = busy ? a_q : '0;
  assign alu_portb = busy ? b_q : '0;
  assign resp_portout = out_q;
  assign resp_zero = z_q;
  assign resp_negative = n_q;
  assign resp_overflow = v_q;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: vector table, corner sequences and random ops against a reference ALU
module tb_alu_share_ctrl;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;
  typedef struct packed {logic [31:0] o; logic z; logic n; logic v;} alu_res_t;
  typedef struct {int r; logic [3:0] op; logic [31:0] a; logic [31:0] b; alu_res_t e;} vec_t;
  logic clk = 1'b0, rst;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0] req_aluop;
  logic [63:0] req_porta, req_portb;
  logic [31:0] resp_portout, alu_porta, alu_portb, alu_portout;
  logic resp_zero, resp_negative, resp_overflow, alu_zero, alu_negative, alu_overflow, busy;
  logic [3:0] alu_aluop, op_count, exp_cnt;
  int total = 0, bad = 0;
  vec_t vecs[6];
  alu_share_ctrl #(.NREQ(2), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_porta(req_porta), .req_portb(req_portb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_portout(resp_portout),
    .resp_zero(resp_zero), .resp_negative(resp_negative), .resp_overflow(resp_overflow),
    .alu_aluop(alu_aluop), .alu_porta(alu_porta), .alu_portb(alu_portb),
    .alu_portout(alu_portout), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .busy(busy), .op_count(op_count)
  );
  always #5 clk = ~clk;
  // overflow = exact signed result does not survive truncation to 32 bits
  function automatic alu_res_t alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    alu_res_t r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADD: s = sa + sb;
      OP_SUB: s = sa - sb;
      OP_AND: s = longint'($signed(a & b));
      OP_OR: s = longint'($signed(a | b));
      OP_XOR: s = longint'($signed(a ^ b));
      default: s = 0;
    endcase
    r.o = 32'(s);
    r.z = r.o == 32'd0;
    r.n = r.o[31];
    r.v = s != longint'($signed(r.o));
    return r;
  endfunction
  always_comb {alu_portout, alu_zero, alu_negative, alu_overflow} = alu_ref(alu_aluop, alu_porta, alu_portb);
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask
  task automatic run_op(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input alu_res_t e);
    logic [1:0] oh;
    oh = 2'(1 << r);
    req_aluop[4*r +: 4] = op;
    req_porta[32*r +: 32] = a;
    req_portb[32*r +: 32] = b;
    req_valid = oh;
    #1 check("grant", 32'(req_ready), 32'(oh));
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("exec_resp_valid", 32'(resp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    check("alu_porta", alu_porta, a);
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'(oh));
    check("portout", resp_portout, e.o);
    check("zero", 32'(resp_zero), 32'(e.z));
    check("negative", 32'(resp_negative), 32'(e.n));
    check("overflow", 32'(resp_overflow), 32'(e.v));
    resp_ready = oh;
    @(posedge clk);
    #1 resp_ready = '0;
    exp_cnt++;
    @(negedge clk);
    check("op_count", 32'(op_count), 32'(exp_cnt));
    check("idle_busy", 32'(busy), 32'd0);
    check("resp_hold", resp_portout, e.o);
  endtask
  initial begin
    vecs[0] = '{0, OP_ADD, 32'd5, 32'd7, alu_res_t'{32'd12, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{1, OP_ADD, 32'h7FFF_FFFF, 32'd1, alu_res_t'{32'h8000_0000, 1'b0, 1'b1, 1'b1}};
    vecs[2] = '{0, OP_SUB, 32'h1234, 32'h1234, alu_res_t'{32'd0, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{1, OP_AND, 32'hF0F0, 32'hFF00, alu_res_t'{32'hF000, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{0, OP_SUB, 32'd0, 32'd1, alu_res_t'{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{1, OP_SUB, 32'h8000_0000, 32'd1, alu_res_t'{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1}};
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_aluop = '0;
    req_porta = '0;
    req_portb = '0;
    exp_cnt = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_aluop", 32'(alu_aluop), 32'd0);
    check("rst_alu_porta", alu_porta, 32'd0);
    check("rst_portout", resp_portout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
    do_reset();
    req_aluop = {OP_ADD, OP_ADD};
    req_porta = {32'd2, 32'd1};
    req_portb = '0;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1 check("rr_grant", 32'(req_ready), (g % 2) ? 32'd2 : 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("rr_exec", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("rr_resp_owner", 32'(resp_valid), (g % 2) ? 32'd2 : 32'd1);
      check("rr_portout", resp_portout, (g % 2) ? 32'd2 : 32'd1);
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
    end
    req_valid = '0;
    resp_ready = '0;
    check("rr_op_count", 32'(op_count), 32'd4);
    req_porta = {32'd2, 32'd3};
    req_portb = {32'd0, 32'd4};
    req_valid = 2'b11;
    #1 check("bp_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_portout", resp_portout, 32'd7);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    resp_ready = 2'b01;
    @(posedge clk);
    #1 resp_ready = '0;
    exp_cnt++;
    @(negedge clk);
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'd2);
    check("bp_op_count", 32'(op_count), 32'(exp_cnt));
    req_valid = '0;
    #1 check("drop_skip", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      int r;
      logic [3:0] op;
      logic [31:0] a, b;
      r = int'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 5));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(r, op, a, b, alu_ref(op, a, b));
    end
    req_aluop[3:0] = OP_ADD;
    req_porta[31:0] = 32'd9;
    req_portb[31:0] = 32'd9;
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_op_count", 32'(op_count), 32'd0);
    check("arst_alu_porta", alu_porta, 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    #1 check("arst_tie", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      run_op(i % 2, OP_XOR, a, b, alu_ref(OP_XOR, a, b));
    end
    check("wrap", 32'(op_count), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
